// File: rtl/iu_pkg.sv
// Shared definitions for the iu_core_p instruction unit: opcode encoding,
// FSM state encoding and the opcode field width.
package iu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_AND   = 4'd2,
        OP_SUB   = 4'd3,
        OP_MUL   = 4'd4,
        OP_LOAD  = 4'd5,
        OP_STORE = 4'd6,
        OP_SRL   = 4'd7,
        OP_SLL   = 4'd8,
        OP_OR    = 4'd9,
        OP_XOR   = 4'd10,
        OP_NAND  = 4'd11,
        OP_INC   = 4'd12
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        FIN    = 3'd4
    } iu_state_t;

endpackage

// File: rtl/iu_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module iu_regfile
    import iu_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int RIDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RIDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see the pre-write contents, so rd == rs1/rs2 is well defined.
    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/iu_core_p.sv
// FSM-sequenced instruction unit: latches one instruction per start/ready
// handshake, runs ALU ops locally and loads/stores over a req/ack port.
module iu_core_p
    import iu_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int NREGS       = 8,
    parameter  int ADDR_W      = 11,
    parameter  int MEM_TIMEOUT = 16,
    localparam int RIDX_W      = $clog2(NREGS),
    localparam int LOW_W       = (ADDR_W > 2*RIDX_W) ? ADDR_W : 2*RIDX_W,
    localparam int INSTR_W     = OPC_W + RIDX_W + LOW_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               ready,
    output logic               done,
    output logic               err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [DATA_W-1:0]  reg_out
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    iu_state_t          state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  reg_out_q, reg_out_d;

    logic [OPC_W-1:0]   opc;
    logic [RIDX_W-1:0]  rd, rs1, rs2, raddr_a;
    logic [ADDR_W-1:0]  addr;
    logic               is_mem;
    logic [DATA_W-1:0]  rdata_a, rdata_b, alu_res, rf_wdata;
    logic               rf_we;

    assign opc     = instr_q[INSTR_W-1 -: OPC_W];
    assign rd      = instr_q[LOW_W +: RIDX_W];
    assign rs1     = instr_q[LOW_W-1 -: RIDX_W];
    assign rs2     = instr_q[RIDX_W-1:0];
    assign addr    = instr_q[ADDR_W-1:0];
    assign is_mem  = (opc == OP_LOAD) || (opc == OP_STORE);
    // A store needs R[rd] on read port A as its write data.
    assign raddr_a = (opc == OP_STORE) ? rd : rs1;

    function automatic logic [DATA_W-1:0] alu(input logic [OPC_W-1:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            OP_ADD:  alu = a + b;
            OP_AND:  alu = a & b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            OP_SRL:  alu = a >> sh;
            OP_SLL:  alu = a << sh;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_NAND: alu = ~(a & b);
            OP_INC:  alu = a + DATA_W'(1);
            default: alu = '0;
        endcase
    endfunction

    assign alu_res = alu(opc, rdata_a, rdata_b);

    iu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (rs2),
        .rdata_b (rdata_b),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        reg_out_d = reg_out_q;
        rf_we     = 1'b0;
        rf_wdata  = alu_res;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (start) begin
                    instr_d = instruction;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opc > OP_INC) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (opc == OP_NOP) begin
                    state_d = FIN;
                end else if (is_mem) begin
                    cnt_d   = '0;
                    state_d = MEM;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rf_we     = 1'b1;
                reg_out_d = alu_res;
                state_d   = FIN;
            end
            MEM: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    if (opc == OP_LOAD) begin
                        rf_we     = 1'b1;
                        rf_wdata  = mem_rdata;
                        reg_out_d = mem_rdata;
                    end
                    state_d = FIN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            reg_out_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            reg_out_q <= reg_out_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign err       = done && err_q;
    assign mem_req   = (state_q == MEM);
    assign mem_we    = mem_req && (opc == OP_STORE);
    assign mem_addr  = mem_req ? addr : '0;
    assign mem_wdata = mem_we ? rdata_a : '0;
    assign reg_out   = reg_out_q;

endmodule

// File: tb/tb_iu_core_p.sv
// Self-checking bench for iu_core_p: table-driven ALU vectors, a reactive
// memory responder, and a done-time scoreboard of {err, reg_out}.
module tb_iu_core_p;
    import iu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] instruction;
    logic        ready, done, err, mem_req, mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, reg_out;
    logic        mem_ack;

    typedef struct packed {
        logic       e;
        logic [7:0] v;
    } sb_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] exp;
    } vec_t;

    sb_t         sb [$];
    vec_t        vecs [11];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  last_reg = 8'h00;

    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    logic [7:0]  ack_data = 8'h00;
    logic        stray_ack = 1'b0;
    int          req_k = 0;
    int          req_len = 0;
    logic [10:0] cap_addr;
    logic        cap_we;
    logic [7:0]  cap_wdata;
    logic        stable_bad = 1'b0;

    iu_core_p dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .reg_out     (reg_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] alu_ins(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, 5'b00000, rs2};
    endfunction

    function automatic logic [17:0] mem_ins(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [10:0] addr);
        return {op, rd, addr};
    endfunction

    // Memory responder: acks ack_delay cycles into a request, records what was asked.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                stray_ack = 1'b0;
            end
            if (mem_req) begin
                if (req_k == 0) begin
                    cap_addr   = mem_addr;
                    cap_we     = mem_we;
                    cap_wdata  = mem_wdata;
                    stable_bad = 1'b0;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    stable_bad = 1'b1;
                end
                if (ack_en && req_k == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                end
                req_k++;
                req_len = req_k;
            end else begin
                req_k = 0;
            end
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending instruction");
            end else begin
                e = sb.pop_front();
                check_output("done_err", {31'b0, err}, {31'b0, e.e});
                check_output("done_reg_out", {24'b0, reg_out}, {24'b0, e.v});
            end
        end
    end

    task automatic apply_stimulus(input logic [17:0] ins, input logic exp_err, input logic [7:0] exp_val,
                                  input int exp_lat, input logic is_mem, input logic exp_we,
                                  input logic [10:0] exp_addr, input logic [7:0] exp_wdata,
                                  input int exp_len, input logic poke);
        int c;
        int w;
        w = 0;
        while (!ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check_output("ready_before_issue", {31'b0, ready}, 32'd1);
        sb.push_back('{e: exp_err, v: exp_val});
        instruction = ins;
        start = 1'b1;
        @(posedge clk); #1;
        start = poke;
        c = 1;
        while (!done && c < 60) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
        end
        check_output("done_seen", {31'b0, done}, 32'd1);
        check_output("latency", c, exp_lat);
        if (is_mem) begin
            check_output("mem_we", {31'b0, cap_we}, {31'b0, exp_we});
            check_output("mem_addr", {21'b0, cap_addr}, {21'b0, exp_addr});
            check_output("mem_wdata", {24'b0, cap_wdata}, {24'b0, exp_wdata});
            check_output("mem_req_cycles", req_len, exp_len);
            check_output("mem_stable", {31'b0, stable_bad}, 32'd0);
        end
        @(posedge clk); #1;
        check_output("done_one_cycle", {31'b0, done}, 32'd0);
        check_output("ready_after_done", {31'b0, ready}, 32'd1);
        last_reg = exp_val;
    endtask

    initial begin
        vecs[0]  = '{op: OP_MUL,  rd: 3'd3, rs1: 3'd1, rs2: 3'd2, exp: 8'hFE};
        vecs[1]  = '{op: OP_SUB,  rd: 3'd4, rs1: 3'd2, rs2: 3'd1, exp: 8'h03};
        vecs[2]  = '{op: OP_SLL,  rd: 3'd5, rs1: 3'd2, rs2: 3'd2, exp: 8'h08};
        vecs[3]  = '{op: OP_SRL,  rd: 3'd0, rs1: 3'd1, rs2: 3'd2, exp: 8'h3F};
        vecs[4]  = '{op: OP_AND,  rd: 3'd6, rs1: 3'd1, rs2: 3'd2, exp: 8'h02};
        vecs[5]  = '{op: OP_OR,   rd: 3'd6, rs1: 3'd5, rs2: 3'd2, exp: 8'h0A};
        vecs[6]  = '{op: OP_XOR,  rd: 3'd7, rs1: 3'd1, rs2: 3'd2, exp: 8'hFD};
        vecs[7]  = '{op: OP_NAND, rd: 3'd0, rs1: 3'd1, rs2: 3'd2, exp: 8'hFD};
        vecs[8]  = '{op: OP_INC,  rd: 3'd4, rs1: 3'd1, rs2: 3'd0, exp: 8'h00};
        vecs[9]  = '{op: OP_ADD,  rd: 3'd1, rs1: 3'd1, rs2: 3'd1, exp: 8'hFE};
        vecs[10] = '{op: OP_ADD,  rd: 3'd6, rs1: 3'd1, rs2: 3'd2, exp: 8'h00};

        rst_n = 1'b0;
        start = 1'b0;
        instruction = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("rst_ready", {31'b0, ready}, 32'd1);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_err", {31'b0, err}, 32'd0);
        check_output("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check_output("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
        check_output("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
        check_output("rst_reg_out", {24'b0, reg_out}, 32'd0);

        ack_en = 1'b1; ack_delay = 2; ack_data = 8'h3C;
        apply_stimulus(mem_ins(OP_LOAD, 3'd1, 11'h005), 1'b0, 8'h3C, 5, 1'b1, 1'b0, 11'h005, 8'h00, 3, 1'b0);
        apply_stimulus(alu_ins(OP_ADD, 3'd2, 3'd1, 3'd1), 1'b0, 8'h78, 3, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b0);

        ack_delay = 0; ack_data = 8'hFF;
        apply_stimulus(mem_ins(OP_LOAD, 3'd1, 11'h010), 1'b0, 8'hFF, 3, 1'b1, 1'b0, 11'h010, 8'h00, 1, 1'b0);
        ack_delay = 1; ack_data = 8'h02;
        apply_stimulus(mem_ins(OP_LOAD, 3'd2, 11'h011), 1'b0, 8'h02, 4, 1'b1, 1'b0, 11'h011, 8'h00, 2, 1'b0);

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(alu_ins(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2), 1'b0, vecs[i].exp,
                           3, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b0);
        end

        ack_delay = 3; ack_data = 8'h99;
        apply_stimulus(mem_ins(OP_STORE, 3'd3, 11'h7FF), 1'b0, last_reg, 6, 1'b1, 1'b1, 11'h7FF, 8'hFE, 4, 1'b0);

        // NOP with an acknowledge arriving outside MEM, which must be ignored.
        stray_ack = 1'b1;
        apply_stimulus(alu_ins(OP_NOP, 3'd0, 3'd0, 3'd0), 1'b0, last_reg, 2, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b0);

        ack_en = 1'b0;
        apply_stimulus(mem_ins(OP_LOAD, 3'd5, 11'h123), 1'b1, last_reg, 18, 1'b1, 1'b0, 11'h123, 8'h00, 16, 1'b0);
        ack_en = 1'b1; ack_delay = 0;
        apply_stimulus(mem_ins(OP_STORE, 3'd5, 11'h000), 1'b0, last_reg, 3, 1'b1, 1'b1, 11'h000, 8'h08, 1, 1'b0);

        ack_delay = 15; ack_data = 8'h5A;
        apply_stimulus(mem_ins(OP_LOAD, 3'd7, 11'h2AA), 1'b0, 8'h5A, 18, 1'b1, 1'b0, 11'h2AA, 8'h00, 16, 1'b0);

        apply_stimulus({4'hE, 14'h0000}, 1'b1, last_reg, 2, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b1);
        apply_stimulus({4'hD, 14'h1234}, 1'b1, last_reg, 2, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b0);

        // Reset while a load is waiting in MEM.
        ack_en = 1'b0;
        instruction = mem_ins(OP_LOAD, 3'd4, 11'h055);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check_output("abort_mem_req_high", {31'b0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_output("abort_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("abort_ready", {31'b0, ready}, 32'd1);
        check_output("abort_done", {31'b0, done}, 32'd0);
        check_output("abort_reg_out", {24'b0, reg_out}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        last_reg = 8'h00;

        ack_en = 1'b1; ack_delay = 0;
        apply_stimulus(mem_ins(OP_STORE, 3'd1, 11'h001), 1'b0, 8'h00, 3, 1'b1, 1'b1, 11'h001, 8'h00, 1, 1'b0);
        apply_stimulus(mem_ins(OP_STORE, 3'd7, 11'h002), 1'b0, 8'h00, 3, 1'b1, 1'b1, 11'h002, 8'h00, 1, 1'b0);
        apply_stimulus(alu_ins(OP_INC, 3'd2, 3'd3, 3'd0), 1'b0, 8'h01, 3, 1'b0, 1'b0, 11'h0, 8'h0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iu_core_p.md
Name: iu_core_p

Overview:
- Parametrised, FSM-sequenced successor to the 8-bit instruction unit.
- Accepts one instruction per start/ready handshake and decodes it.
- ALU ops: executed internally, result written to the register file. Loads/stores: issued over a req/ack memory handshake with a timeout.
- Completion is signalled by a one-cycle done pulse, plus an err flag for illegal opcodes and memory timeouts.
- Sits between the instruction sequencer and the memory fetch unit.

Parameters:
- DATA_W, 8: register and datapath width.
- NREGS, 8: register count, power of 2; RIDX_W = $clog2(NREGS).
- ADDR_W, 11: memory address width.
- MEM_TIMEOUT, 16: max cycles waiting for mem_ack before abort; must be ≥1.
- INSTR_W (derived, not overridable): 4 + RIDX_W + max(ADDR_W, 2*RIDX_W) = 18 at defaults.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: instruction valid; accepted when start && ready.
- instruction, input, INSTR_W: [top 4] opcode, then rd; low bits are {rs1, pad, rs2} for ALU ops, addr[ADDR_W-1:0] for load/store.
- ready, output, 1: high in IDLE only.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: qualifies done; 1 = illegal opcode or memory timeout.
- mem_req, output, 1: memory request, held until ack or timeout.
- mem_we, output, 1: 1 = store, 0 = load; valid while mem_req.
- mem_addr, output, ADDR_W: request address.
- mem_wdata, output, DATA_W: store data = R[rd].
- mem_rdata, input, DATA_W: load data, sampled on the mem_ack cycle.
- mem_ack, input, 1: one-cycle acknowledge.
- reg_out, output, DATA_W: last value written to the register file (debug).

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - State goes to IDLE; all registers R[0..NREGS-1] cleared to 0.
  - ready=1 the following cycle; done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_out=0.
  - Reset mid-operation aborts it: no register write, mem_req drops, no done.
- Acceptance:
  - On start && ready, the instruction is latched; decode uses only the latched copy.
  - start while not ready is ignored, with no queuing.
- Opcodes (4-bit):
  - 0 NOP.
  - 1 ADD, 2 AND, 3 SUB, 4 MUL (low DATA_W bits).
  - 5 LOAD, 6 STORE.
  - 7 SRL, 8 SLL: shift amount = R[rs2][$clog2(DATA_W)-1:0].
  - 9 OR, 10 XOR, 11 NAND, 12 INC (R[rs1]+1).
  - 13–15 illegal.
  - All arithmetic wraps modulo 2^DATA_W.
- States:
  - IDLE → DECODE on accept.
  - DECODE → EXEC (ALU op), MEM (load/store), or FIN (NOP/illegal).
  - EXEC: R[rd] <= f(R[rs1], R[rs2]) and reg_out updated at the end of the cycle; → FIN.
  - MEM: mem_req=1, mem_addr = latched addr, mem_we = (op==STORE). A cycle counter starts at 0.
    - On mem_ack: a LOAD writes R[rd] <= mem_rdata and reg_out; → FIN.
    - Counter reaching MEM_TIMEOUT without ack: set err, no write; → FIN.
  - FIN: done=1 for exactly one cycle (err=1 if illegal or timeout); → IDLE.
- Latency, counting the accept edge as cycle 0:
  - ALU: done in cycle 3.
  - NOP/illegal: done in cycle 2.
  - Memory: done 1 cycle after the cycle in which mem_ack is sampled.
- Handshake edges:
  - mem_req is driven from state, so it falls the cycle after mem_ack.
  - mem_ack outside MEM is ignored.
  - mem_ack arriving on the same cycle the counter hits MEM_TIMEOUT counts as success.
- Hazards: rd may equal rs1/rs2; operands are read before the write, so R[1]=R[1]+R[1] is well-defined.
- ready returns to 1 in the cycle after done; back-to-back instructions are supported with no bubble beyond FIN.

Decomposition:
- Package iu_pkg holds:
  - opcode_t enum (values above).
  - iu_state_t enum {IDLE, DECODE, EXEC, MEM, FIN}.
  - Opcode field width constant OPC_W=4.
- One sub-module, iu_regfile: NREGS×DATA_W, two asynchronous read ports, one synchronous write port, synchronous active-low clear. The top level holds the FSM, ALU function and memory interface.

Test Plan:
- Reset, then R1 ← LOAD addr 0x005 with ack rdata=0x3C after 2 cycles, then ADD R2=R1+R1 → reg_out=0x78, done pulses, err=0.
- R1=0xFF, R2=0x02, MUL R3=R1*R2 → R3=0xFE; SUB R4=R2-R1 → 0x03; SLL R5=R2<<R2 → 0x08.
- STORE R3 addr 0x7FF → mem_req=1, mem_we=1, mem_addr=0x7FF, mem_wdata=0xFE until ack; done the cycle after; no register change.
- LOAD with mem_ack never asserted → after MEM_TIMEOUT=16 cycles mem_req drops, done=1 and err=1, target register unchanged.
- Opcode 4'hE → done=1, err=1 two cycles after accept; start pulsed while busy → ignored (exactly one done).
- rst_n=0 asserted while in MEM → next cycle mem_req=0, ready=1, all registers read 0, no done.
